// File: rtl/uv_led_pid_sequencer.sv
// Control-period sequencer for the UV-LED PID current loop: triggers one ADC sample per
// period, soft-start ramps the target, and shuts the loop down on ADC timeout or regulation error.
module uv_led_pid_sequencer #(
  parameter int unsigned TICK_DIV    = 1000,
  parameter logic [31:0] RAMP_STEP   = 32'd16,
  parameter logic [31:0] ERR_LIMIT   = 32'd200,
  parameter int unsigned FAULT_CNT   = 8,
  parameter int unsigned ADC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] P_set,
  output logic        adc_start,
  input  logic        adc_valid,
  input  logic [31:0] adc_data,
  output logic        pid_rst_n,
  output logic [31:0] pid_target,
  output logic [31:0] pid_measure,
  output logic        pid_update,
  output logic        led_en,
  output logic        ramp_done,
  output logic        overrun,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [15:0]   WAIT_LAST  = 16'(ADC_TIMEOUT - 1);
  localparam logic [7:0]    FAULT_LAST = 8'(FAULT_CNT);

  typedef enum logic [2:0] {IDLE, START, WAIT_ADC, UPDATE, HOLD, FAULT} state_t;

  state_t      state, state_nx;
  logic [CW-1:0] per_cnt, per_cnt_nx;
  logic [15:0] wait_cnt, wait_cnt_nx;
  logic [7:0]  err_cnt, err_cnt_nx;
  logic        adc_start_nx, pid_rst_n_nx, pid_update_nx, ramp_done_nx;
  logic        overrun_nx, fault_nx;
  logic [1:0]  fault_code_nx;
  logic [31:0] pid_target_nx, pid_measure_nx;

  logic        active, tick;
  logic [32:0] ramp_sum;
  logic [31:0] new_target, abs_err;
  logic [7:0]  err_inc;

  assign active     = (state == START) || (state == WAIT_ADC) || (state == UPDATE) || (state == HOLD);
  assign tick       = active && (per_cnt == TICK_LAST);
  assign ramp_sum   = {1'b0, pid_target} + {1'b0, RAMP_STEP};
  assign new_target = (P_set <= pid_target) ? P_set :
                      ((ramp_sum >= {1'b0, P_set}) ? P_set : ramp_sum[31:0]);
  assign abs_err    = (pid_target >= pid_measure) ? (pid_target - pid_measure)
                                                  : (pid_measure - pid_target);
  assign err_inc    = err_cnt + 8'd1;
  assign led_en     = pid_rst_n;

  always_comb begin
    state_nx       = state;
    per_cnt_nx     = '0;
    wait_cnt_nx    = wait_cnt;
    err_cnt_nx     = err_cnt;
    adc_start_nx   = 1'b0;
    pid_update_nx  = 1'b0;
    pid_rst_n_nx   = pid_rst_n;
    pid_target_nx  = pid_target;
    pid_measure_nx = pid_measure;
    ramp_done_nx   = ramp_done;
    fault_nx       = fault;
    fault_code_nx  = fault_code;
    overrun_nx     = enable && tick && (state != HOLD);

    if (active) per_cnt_nx = tick ? '0 : per_cnt + CW'(1);

    case (state)
      IDLE:     if (enable) state_nx = START;
      START: begin
        wait_cnt_nx = '0;
        state_nx    = WAIT_ADC;
      end
      WAIT_ADC: begin
        if (adc_valid) begin
          pid_measure_nx = adc_data;
          pid_target_nx  = new_target;
          ramp_done_nx   = (new_target == P_set);
          pid_rst_n_nx   = 1'b1;
          state_nx       = UPDATE;
        end else if (wait_cnt == WAIT_LAST) begin
          fault_code_nx = 2'd1;
          state_nx      = FAULT;
        end else begin
          wait_cnt_nx = wait_cnt + 16'd1;
        end
      end
      UPDATE: begin
        state_nx = HOLD;
        if (ramp_done && (abs_err > ERR_LIMIT)) begin
          err_cnt_nx = err_inc;
          if (err_inc == FAULT_LAST) begin
            fault_code_nx = 2'd2;
            state_nx      = FAULT;
          end
        end else begin
          err_cnt_nx = '0;
        end
      end
      HOLD:     if (tick) state_nx = START;
      FAULT:    if (!enable) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase

    if (active && !enable) state_nx = IDLE;

    // Registered outputs are derived from the state being entered, so they line up with it.
    case (state_nx)
      IDLE: begin
        per_cnt_nx     = '0;
        wait_cnt_nx    = '0;
        err_cnt_nx     = '0;
        pid_rst_n_nx   = 1'b0;
        pid_target_nx  = '0;
        pid_measure_nx = '0;
        ramp_done_nx   = 1'b0;
        overrun_nx     = 1'b0;
        fault_nx       = 1'b0;
        fault_code_nx  = 2'd0;
      end
      FAULT: begin
        pid_rst_n_nx   = 1'b0;
        pid_target_nx  = '0;
        pid_measure_nx = '0;
        ramp_done_nx   = 1'b0;
        overrun_nx     = 1'b0;
        fault_nx       = 1'b1;
      end
      START:   adc_start_nx  = 1'b1;
      UPDATE:  pid_update_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      per_cnt     <= '0;
      wait_cnt    <= '0;
      err_cnt     <= '0;
      adc_start   <= 1'b0;
      pid_rst_n   <= 1'b0;
      pid_target  <= '0;
      pid_measure <= '0;
      pid_update  <= 1'b0;
      ramp_done   <= 1'b0;
      overrun     <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'd0;
    end else begin
      state       <= state_nx;
      per_cnt     <= per_cnt_nx;
      wait_cnt    <= wait_cnt_nx;
      err_cnt     <= err_cnt_nx;
      adc_start   <= adc_start_nx;
      pid_rst_n   <= pid_rst_n_nx;
      pid_target  <= pid_target_nx;
      pid_measure <= pid_measure_nx;
      pid_update  <= pid_update_nx;
      ramp_done   <= ramp_done_nx;
      overrun     <= overrun_nx;
      fault       <= fault_nx;
      fault_code  <= fault_code_nx;
    end
  end

endmodule

// File: tb/tb_uv_led_pid_sequencer.sv
// Self-checking bench for uv_led_pid_sequencer: a behavioural ramp/error/period model
// is compared against the DUT while a scripted ADC answers with randomized latency.
module tb_uv_led_pid_sequencer;

  localparam int TICK   = 20;
  localparam int RAMP   = 16;
  localparam int ERRLIM = 200;
  localparam int FCNT   = 8;

  logic        clk, rst, enable, adc_valid;
  logic [31:0] P_set, adc_data;
  logic        adc_start, pid_rst_n, pid_update, led_en, ramp_done, overrun, fault;
  logic [31:0] pid_target, pid_measure;
  logic [1:0]  fault_code;

  int vectors, miscompares;
  int cyc, ovr_total;
  int prev_cyc, prev_ovr, exp_gap, exp_ovr, last_wait;
  bit have_prev, m_started;
  logic [31:0] m_target;
  int m_err;

  uv_led_pid_sequencer #(.TICK_DIV(TICK)) dut (
    .clk(clk), .rst(rst), .enable(enable), .P_set(P_set),
    .adc_start(adc_start), .adc_valid(adc_valid), .adc_data(adc_data),
    .pid_rst_n(pid_rst_n), .pid_target(pid_target), .pid_measure(pid_measure),
    .pid_update(pid_update), .led_en(led_en), .ramp_done(ramp_done),
    .overrun(overrun), .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] nextTarget(input logic [31:0] cur, input logic [31:0] pset);
    longint c, p;
    c = cur;
    p = pset;
    if (p <= c) return pset;
    if (c + RAMP >= p) return pset;
    return cur + RAMP;
  endfunction

  function automatic longint absDiff(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = a;
    y = b;
    return (x > y) ? x - y : y - x;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_adc_start"}, adc_start, 0);
    checkOutput({tag, "_pid_rst_n"}, pid_rst_n, 0);
    checkOutput({tag, "_led_en"}, led_en, 0);
    checkOutput({tag, "_pid_target"}, pid_target, 0);
    checkOutput({tag, "_pid_measure"}, pid_measure, 0);
    checkOutput({tag, "_pid_update"}, pid_update, 0);
    checkOutput({tag, "_ramp_done"}, ramp_done, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
    checkOutput({tag, "_fault"}, fault, 0);
    checkOutput({tag, "_fault_code"}, fault_code, 0);
  endtask

  // Every clock step goes through here so overrun pulses are counted exactly once.
  task automatic stepClock();
    @(negedge clk);
    cyc++;
    if (overrun === 1'b1) ovr_total++;
  endtask

  task automatic waitStart(output int n);
    n = 0;
    do begin
      stepClock();
      n++;
    end while (adc_start !== 1'b1 && n < 200);
    if (adc_start !== 1'b1) checkOutput("start_wait", adc_start, 1);
  endtask

  task automatic startRun();
    enable    = 1'b1;
    m_target  = '0;
    m_err     = 0;
    m_started = 1'b0;
    have_prev = 1'b0;
  endtask

  // One control period: wait for START, answer after 'delay' cycles, check the update.
  task automatic applyStimulus(input int delay, input logic [31:0] data);
    int n, over, k;
    waitStart(n);
    last_wait = n;
    if (!m_started) checkOutput("rst_n_before_sample", pid_rst_n, 0);
    if (have_prev) begin
      checkOutput("start_gap", cyc - prev_cyc, exp_gap);
      checkOutput("overrun_count", ovr_total - prev_ovr, exp_ovr);
    end
    prev_cyc  = cyc;
    prev_ovr  = ovr_total;
    have_prev = 1'b1;
    // Next START waits for the first tick that lands in HOLD; earlier ticks are overruns.
    over    = delay - (TICK - 3);
    k       = (over <= 0) ? 0 : (over + TICK - 1) / TICK;
    exp_gap = TICK * (k + 1);
    exp_ovr = k;
    repeat (delay) stepClock();
    adc_valid = 1'b1;
    adc_data  = data;
    stepClock();
    adc_valid = 1'b0;
    adc_data  = $urandom;
    m_target  = nextTarget(m_target, P_set);
    m_started = 1'b1;
    checkOutput("pid_update", pid_update, 1);
    checkOutput("pid_target", pid_target, m_target);
    checkOutput("pid_measure", pid_measure, data);
    checkOutput("ramp_done", ramp_done, (m_target == P_set) ? 1 : 0);
    checkOutput("pid_rst_n", pid_rst_n, 1);
    checkOutput("led_en", led_en, 1);
    if (m_target == P_set && absDiff(m_target, data) > ERRLIM) m_err++;
    else m_err = 0;
    stepClock();
    if (m_err == FCNT) begin
      checkOutput("reg_fault", fault, 1);
      checkOutput("reg_fault_code", fault_code, 2);
      checkOutput("reg_fault_rst_n", pid_rst_n, 0);
      checkOutput("reg_fault_led_en", led_en, 0);
      checkOutput("reg_fault_target", pid_target, 0);
      checkOutput("reg_fault_measure", pid_measure, 0);
      have_prev = 1'b0;
    end else begin
      checkOutput("no_fault", fault, 0);
      checkOutput("update_one_cycle", pid_update, 0);
    end
  endtask

  task automatic rampTo(input logic [31:0] goal);
    logic [31:0] nt;
    P_set = goal;
    for (int i = 0; i < 100 && m_target != P_set; i++) begin
      nt = nextTarget(m_target, P_set);
      applyStimulus($urandom_range(1, 30), (nt == P_set) ? nt : nt + $urandom_range(0, 2000));
    end
    checkOutput("ramp_reached", ramp_done, 1);
  endtask

  initial begin
    int n;
    vectors = 0; miscompares = 0; cyc = 0; ovr_total = 0;
    rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_data = '0; P_set = '0;
    m_target = '0; m_err = 0; m_started = 1'b0; have_prev = 1'b0; last_wait = 0;
    repeat (2) stepClock();
    checkAllZero("reset");
    rst = 1'b0;
    stepClock();
    checkAllZero("idle");

    $display("[TB] soft start and overrun");
    P_set = 32'd40;
    startRun();
    applyStimulus(3, 0);
    checkOutput("enable_to_start", last_wait, 1);
    applyStimulus(3, 0);
    applyStimulus(3, 0);
    checkOutput("soft_start_final", pid_target, 40);
    applyStimulus(25, 40);
    applyStimulus(25, 40);
    applyStimulus(3, 40);

    $display("[TB] ramp and regulation fault");
    rampTo(32'd1000);
    repeat (7) applyStimulus($urandom_range(1, 10), 799);
    applyStimulus(2, 1000);
    repeat (10) applyStimulus($urandom_range(1, 30), 800);
    repeat (8) applyStimulus($urandom_range(1, 10), 799);
    repeat (5) begin
      stepClock();
      checkOutput("fault_hold", fault, 1);
      checkOutput("fault_no_start", adc_start, 0);
    end
    enable = 1'b0;
    stepClock();
    checkOutput("fault_clear", fault, 0);
    checkOutput("fault_code_clear", fault_code, 0);

    $display("[TB] target decrease and stray valid");
    startRun();
    rampTo(32'd1000);
    P_set = 32'd500;
    applyStimulus(2, 500);
    adc_valid = 1'b1;
    adc_data  = 32'd12345;
    stepClock();
    adc_valid = 1'b0;
    checkOutput("stray_valid_measure", pid_measure, 500);
    checkOutput("stray_valid_update", pid_update, 0);
    P_set = 32'd600;
    applyStimulus($urandom_range(1, 30), 516);
    applyStimulus($urandom_range(1, 30), 532);

    $display("[TB] adc timeout");
    waitStart(n);
    n = 0;
    do begin
      stepClock();
      n++;
    end while (fault !== 1'b1 && n < 400);
    checkOutput("timeout_latency", n, 256);
    checkOutput("timeout_code", fault_code, 1);
    checkOutput("timeout_rst_n", pid_rst_n, 0);
    checkOutput("timeout_target", pid_target, 0);
    repeat (3) begin
      stepClock();
      checkOutput("timeout_fault_hold", fault, 1);
    end
    enable = 1'b0;
    stepClock();
    checkOutput("timeout_fault_clear", fault, 0);
    checkOutput("timeout_code_clear", fault_code, 0);

    $display("[TB] abort during WAIT_ADC");
    P_set = 32'd1000;
    startRun();
    waitStart(n);
    repeat (2) stepClock();
    enable = 1'b0;
    stepClock();
    checkOutput("abort_adc_start", adc_start, 0);
    checkOutput("abort_rst_n", pid_rst_n, 0);
    adc_valid = 1'b1;
    adc_data  = 32'd777;
    stepClock();
    adc_valid = 1'b0;
    checkOutput("abort_measure", pid_measure, 0);
    checkOutput("abort_update", pid_update, 0);
    checkOutput("abort_target", pid_target, 0);

    $display("[TB] async reset during UPDATE");
    startRun();
    applyStimulus(3, 0);
    waitStart(n);
    repeat (2) stepClock();
    adc_valid = 1'b1;
    adc_data  = 32'd50;
    stepClock();
    adc_valid = 1'b0;
    checkOutput("pre_reset_update", pid_update, 1);
    #2 rst = 1'b1;
    #1 checkAllZero("async_rst");
    stepClock();
    rst = 1'b0;
    startRun();
    applyStimulus(3, 0);
    checkOutput("restart_target", pid_target, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
